decoder_2_to_4: RTL and testbench

//   2-to-4 binary decoder with active-high enable, gate-level decode core.

---
 rtl/decoder_2_to_4_if.sv | 20 ++
 rtl/decoder_2_to_4.sv | 52 +++++
 tb/tb_decoder_2_to_4.sv | 131 +++++++++++++
 3 files changed

// File: rtl/decoder_2_to_4_if.sv
// Bus bundle for the 2-to-4 decoder: enable and select code in, one-hot strobe out.
interface decoder_2_to_4_if;
    logic       en;
    logic [1:0] a;
    logic [3:0] bcode;

    // The driving side supplies the enable and code, then observes the strobes
    modport master (
        output en,
        output a,
        input  bcode
    );

    // The decoder consumes the enable and code, then drives the strobes
    modport slave (
        input  en,
        input  a,
        output bcode
    );
endinterface

// File: rtl/decoder_2_to_4.sv
// 2-to-4 binary decoder with active-high enable and a gate-level decode core.
// When enabled, exactly one of the four strobes is high, chosen by the 2-bit code;
// when disabled, all strobes are low. The output is either registered (one clock
// of latency, synchronous active-high reset) or purely combinational.
module decoder_2_to_4 #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    decoder_2_to_4_if.slave  dec
);

    logic [3:0] bcode_d;

    // Gate-level decode: each strobe is the AND of en with one minterm of a
    always_comb begin
        bcode_d    = 4'b0000;
        bcode_d[0] = dec.en & ~dec.a[1] & ~dec.a[0];
        bcode_d[1] = dec.en & ~dec.a[1] &  dec.a[0];
        bcode_d[2] = dec.en &  dec.a[1] & ~dec.a[0];
        bcode_d[3] = dec.en &  dec.a[1] &  dec.a[0];
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [3:0] out_d;
            logic [3:0] out_q;

            // Next output value: reset forces all strobes low, overriding en and a
            always_comb begin
                out_d = bcode_d;
                if (reset) begin
                    out_d = 4'b0000;
                end
            end

            // Output register; the only state in the block
            always_ff @(posedge clk) begin
                out_q <= out_d;
            end

            assign dec.bcode = out_q;
        end else begin : g_comb
            // Clock and reset play no part in the combinational build
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;

            assign dec.bcode = bcode_d;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_2_to_4.sv
// Scoreboard bench for decoder_2_to_4: one registered and one combinational
// instance driven with the same directed vectors.
module tb_decoder_2_to_4;

    logic clk;
    logic reset;

    decoder_2_to_4_if if_reg ();
    decoder_2_to_4_if if_comb ();

    decoder_2_to_4 #(.OUT_REG(1'b1)) u_dut_reg (
        .clk   (clk),
        .reset (reset),
        .dec   (if_reg.slave)
    );

    decoder_2_to_4 #(.OUT_REG(1'b0)) u_dut_comb (
        .clk   (clk),
        .reset (reset),
        .dec   (if_comb.slave)
    );

    typedef struct {
        logic [3:0] exp_reg;
        logic [3:0] exp_comb;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector at the falling edge and queue the response expected after
    // the next rising edge (registered) and while the vector is held (combinational).
    task automatic apply(input logic r, input logic e, input logic [1:0] av,
                         input logic [3:0] er, input logic [3:0] ec, input string nm);
        exp_t x;
        @(negedge clk);
        reset      = r;
        if_reg.en  = e;
        if_reg.a   = av;
        if_comb.en = e;
        if_comb.a  = av;
        x.exp_reg  = er;
        x.exp_comb = ec;
        x.name     = nm;
        sb_q.push_back(x);
    endtask

    // Monitor: just after each rising edge, pop one expectation and compare
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                checks++;
                if (if_reg.bcode !== cur.exp_reg) begin
                    errors++;
                    $display("FAIL %s reg: got %b expected %b", cur.name, if_reg.bcode, cur.exp_reg);
                end
                checks++;
                if (if_comb.bcode !== cur.exp_comb) begin
                    errors++;
                    $display("FAIL %s comb: got %b expected %b", cur.name, if_comb.bcode, cur.exp_comb);
                end
                checks++;
                if (!$onehot0(if_reg.bcode) || !$onehot0(if_comb.bcode)) begin
                    errors++;
                    $display("FAIL %s onehot0: got reg %b comb %b expected at most one bit set",
                             cur.name, if_reg.bcode, if_comb.bcode);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        if_reg.en  = 1'b0;
        if_reg.a   = 2'b00;
        if_comb.en = 1'b0;
        if_comb.a  = 2'b00;

        // 1: reset held two clocks with en=1, a=10, then release
        apply(1'b1, 1'b1, 2'b10, 4'b0000, 4'b0100, "rst_hold0");
        apply(1'b1, 1'b1, 2'b10, 4'b0000, 4'b0100, "rst_hold1");
        apply(1'b0, 1'b1, 2'b10, 4'b0100, 4'b0100, "rst_release");

        // 2: disabled, each code held 200 ns (20 clocks)
        for (int i = 0; i < 20; i++) apply(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, "dis_a00");
        for (int i = 0; i < 20; i++) apply(1'b0, 1'b0, 2'b01, 4'b0000, 4'b0000, "dis_a01");
        for (int i = 0; i < 20; i++) apply(1'b0, 1'b0, 2'b10, 4'b0000, 4'b0000, "dis_a10");
        for (int i = 0; i < 20; i++) apply(1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, "dis_a11");

        // 3: enabled sweep
        apply(1'b0, 1'b1, 2'b00, 4'b0001, 4'b0001, "en_a00");
        apply(1'b0, 1'b1, 2'b01, 4'b0010, 4'b0010, "en_a01");
        apply(1'b0, 1'b1, 2'b10, 4'b0100, 4'b0100, "en_a10");
        apply(1'b0, 1'b1, 2'b11, 4'b1000, 4'b1000, "en_a11");

        // 4: enable toggling with a=11
        apply(1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, "en_drop");
        apply(1'b0, 1'b1, 2'b11, 4'b1000, 4'b1000, "en_restore");

        // 5: reset mid-operation with en=1, a=01
        apply(1'b0, 1'b1, 2'b01, 4'b0010, 4'b0010, "mid_pre");
        apply(1'b1, 1'b1, 2'b01, 4'b0000, 4'b0010, "mid_reset");
        apply(1'b0, 1'b1, 2'b01, 4'b0010, 4'b0010, "mid_release");

        // Reverse sweep to catch stuck or swapped strobes
        apply(1'b0, 1'b1, 2'b11, 4'b1000, 4'b1000, "rev_a11");
        apply(1'b0, 1'b1, 2'b00, 4'b0001, 4'b0001, "rev_a00");
        apply(1'b0, 1'b1, 2'b10, 4'b0100, 4'b0100, "rev_a10");
        apply(1'b0, 1'b0, 2'b10, 4'b0000, 4'b0000, "rev_dis");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
